// File: rtl/alu_seq.sv
// alu_seq: command/result sequencer placed in front of the 8-bit ALU.
// It registers an operation, drives the ALU with oe_out for a fixed settle
// window, captures the 16-bit result and hands it out over a valid/ready
// interface. A local accumulator lets a result feed the next operand A.
module alu_seq #(
    parameter int SETTLE_CYCLES = 1,
    parameter int CNT_W         = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid_in,
    output logic             cmd_ready_out,
    input  logic [3:0]       command_in,
    input  logic [7:0]       a_in,
    input  logic [7:0]       b_in,
    input  logic             use_acc_in,
    input  logic             acc_clear_in,
    output logic             oe_out,
    output logic [3:0]       alu_cmd_out,
    output logic [7:0]       alu_a_out,
    output logic [7:0]       alu_b_out,
    input  logic [15:0]      alu_d_in,
    output logic             res_valid_out,
    input  logic             res_ready_in,
    output logic [15:0]      res_out,
    output logic             zero_out,
    output logic             ovf_out,
    output logic             acc_valid_out,
    output logic             busy_out,
    output logic [CNT_W-1:0] op_count_out
);

    // A settle window of zero would never capture anything, so it is treated as one.
    localparam int SETTLE_EFF = (SETTLE_CYCLES < 1) ? 1 : SETTLE_CYCLES;
    localparam int SETTLE_W   = $clog2(SETTLE_EFF + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRIVE  = 2'd1,
        RESULT = 2'd2
    } state_t;

    state_t              state;
    state_t              next_state;
    logic [SETTLE_W-1:0] settle_cnt;
    logic [7:0]          acc;
    logic                acc_valid;
    logic [CNT_W-1:0]    op_count;
    logic                accept;
    logic                capture;

    assign accept  = (state == IDLE) && cmd_valid_in;
    assign capture = (state == DRIVE) && (settle_cnt == SETTLE_W'(1));

    // State register; reset abandons any operation in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    // Next-state logic and the handshake/enable outputs decoded from state.
    always_comb begin
        next_state    = state;
        cmd_ready_out = 1'b0;
        oe_out        = 1'b0;
        res_valid_out = 1'b0;
        case (state)
            IDLE: begin
                cmd_ready_out = 1'b1;
                if (cmd_valid_in) next_state = DRIVE;
            end
            DRIVE: begin
                oe_out = 1'b1;
                if (settle_cnt == SETTLE_W'(1)) next_state = RESULT;
            end
            RESULT: begin
                res_valid_out = 1'b1;
                if (res_ready_in) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Settle counter: loaded on accept, counts down while the ALU is driven.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            settle_cnt <= '0;
        end else if (accept) begin
            settle_cnt <= SETTLE_W'(SETTLE_EFF);
        end else if ((state == DRIVE) && (settle_cnt != '0)) begin
            settle_cnt <= settle_cnt - 1'b1;
        end
    end

    // ALU-facing operand registers; they keep their values outside DRIVE so only oe_out moves.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_cmd_out <= '0;
            alu_a_out   <= '0;
            alu_b_out   <= '0;
        end else if (accept) begin
            alu_cmd_out <= command_in;
            alu_b_out   <= b_in;
            alu_a_out   <= (use_acc_in && acc_valid && !acc_clear_in) ? acc : a_in;
        end
    end

    // Result register, loaded only in the last settle cycle when the bus is known-good.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)          res_out <= '0;
        else if (capture) res_out <= alu_d_in;
    end

    // Accumulator; only its low byte can ever feed operand A, so only that is kept.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc       <= '0;
            acc_valid <= 1'b0;
        end else if (capture) begin
            acc       <= alu_d_in[7:0];
            acc_valid <= !acc_clear_in;
        end else if (acc_clear_in) begin
            acc_valid <= 1'b0;
        end
    end

    // Completed-operation counter, free-running and wrapping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)          op_count <= '0;
        else if (capture) op_count <= op_count + 1'b1;
    end

    assign zero_out      = res_valid_out && (res_out == 16'h0000);
    assign ovf_out       = res_valid_out && (res_out[15:8] != 8'h00);
    assign acc_valid_out = acc_valid;
    assign busy_out      = (state != IDLE);
    assign op_count_out  = op_count;

endmodule
